// File: rtl/serial_mul_pkg.sv
// serial_mul_pkg: shared FSM encoding and parameter helpers for the serial multiplier.
package serial_mul_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int steps_f(input int op_y_width, input int bits_per_cycle);
      return op_y_width / bits_per_cycle;
   endfunction
   function automatic bit params_ok(input int op_x_width, input int op_y_width, input int bits_per_cycle);
      return op_x_width >= 2 && op_y_width >= 2 && bits_per_cycle >= 1 && op_y_width % bits_per_cycle == 0;
   endfunction
endpackage

// File: rtl/serial_mul_if.sv
// serial_mul_if: operand/handshake/result bundle between the front end and the multiplier.
interface serial_mul_if #(
   parameter int OP_X_WIDTH = 16,
   parameter int OP_Y_WIDTH = 16
);
   localparam int RES_WIDTH = OP_X_WIDTH + OP_Y_WIDTH;
   logic                  start;
   logic                  signed_mode;
   logic [OP_X_WIDTH-1:0] in_x;
   logic [OP_Y_WIDTH-1:0] in_y;
   logic                  ready;
   logic                  valid_out;
   logic [RES_WIDTH-1:0]  out_mul;
   modport master (output start, signed_mode, in_x, in_y, input ready, valid_out, out_mul);
   modport slave  (input start, signed_mode, in_x, in_y, output ready, valid_out, out_mul);
endinterface

// File: rtl/serial_mul_pp.sv
// serial_mul_pp: signed partial product of an extended multiplicand and one multiplier digit.
module serial_mul_pp #(
   parameter int OP_X_WIDTH     = 16,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic signed [OP_X_WIDTH:0]                x_i,
   input  logic        [BITS_PER_CYCLE-1:0]          digit_i,
   input  logic                                      last_signed_i,
   output logic signed [OP_X_WIDTH+BITS_PER_CYCLE:0] pp_o
);
   localparam int PW = OP_X_WIDTH + BITS_PER_CYCLE + 1;
   logic signed [PW-1:0] x_w;
   logic signed [PW-1:0] d_w;
   // Only the top digit of a signed multiplier carries negative weight.
   always_comb begin
      x_w  = {{BITS_PER_CYCLE{x_i[OP_X_WIDTH]}}, x_i};
      d_w  = {{(PW-BITS_PER_CYCLE){last_signed_i & digit_i[BITS_PER_CYCLE-1]}}, digit_i};
      pp_o = x_w * d_w;
   end
endmodule

// File: rtl/serial_multiplier_ext.sv
// serial_multiplier_ext: multi-cycle shift-and-add multiplier retiring BITS_PER_CYCLE
// multiplier bits per cycle, unsigned or two's-complement, behind a ready/start handshake.
module serial_multiplier_ext
   import serial_mul_pkg::*;
#(
   parameter int OP_X_WIDTH     = 16,
   parameter int OP_Y_WIDTH     = 16,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic         clk,
   input logic         rst_n,
   serial_mul_if.slave bus
);
   localparam int RES_WIDTH = OP_X_WIDTH + OP_Y_WIDTH;
   localparam int STEPS     = steps_f(OP_Y_WIDTH, BITS_PER_CYCLE);
   localparam int CW        = $clog2(STEPS + 1);
   localparam int PW        = OP_X_WIDTH + BITS_PER_CYCLE + 1;
   localparam int TW        = RES_WIDTH + BITS_PER_CYCLE;

   if (!params_ok(OP_X_WIDTH, OP_Y_WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
      $error("serial_multiplier_ext: illegal OP_X_WIDTH/OP_Y_WIDTH/BITS_PER_CYCLE");
   end

   state_t                  state_q;
   logic [OP_X_WIDTH-1:0]   x_q;
   logic [OP_Y_WIDTH-1:0]   y_q;
   logic                    signed_q;
   logic [CW-1:0]           cnt_q;
   logic [RES_WIDTH-1:0]    acc_q;
   logic [RES_WIDTH-1:0]    out_q;
   logic                    ready_q;
   logic                    valid_q;
   logic signed [PW-1:0]    pp;
   logic [TW-1:0]           sum_d;
   logic [RES_WIDTH-1:0]    acc_d;

   serial_mul_pp #(
      .OP_X_WIDTH    (OP_X_WIDTH),
      .BITS_PER_CYCLE(BITS_PER_CYCLE)
   ) u_pp (
      .x_i          ({signed_q & x_q[OP_X_WIDTH-1], x_q}),
      .digit_i      (y_q[BITS_PER_CYCLE-1:0]),
      .last_signed_i(signed_q && cnt_q == '0),
      .pp_o         (pp)
   );

   // Partial product enters at the top; the accumulator shifts right so each digit lands at its weight.
   always_comb begin
      sum_d = {{BITS_PER_CYCLE{signed_q & acc_q[RES_WIDTH-1]}}, acc_q} + ({{(TW-PW){pp[PW-1]}}, pp} << OP_Y_WIDTH);
      acc_d = sum_d[TW-1:BITS_PER_CYCLE];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         signed_q <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         out_q    <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               valid_q <= 1'b0;
               if (bus.start) begin
                  x_q      <= bus.in_x;
                  y_q      <= bus.in_y;
                  signed_q <= bus.signed_mode;
                  acc_q    <= '0;
                  cnt_q    <= CW'(STEPS - 1);
                  ready_q  <= 1'b0;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               y_q   <= y_q >> BITS_PER_CYCLE;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  out_q   <= acc_d;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ready     = ready_q;
   assign bus.valid_out = valid_q;
   assign bus.out_mul   = out_q;
endmodule

// File: tb/tb_serial_multiplier_ext.sv
// tb_serial_multiplier_ext: scoreboard bench for B=1 and B=4 instances sharing one clock/reset.
module tb_serial_multiplier_ext;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_mul_if #(.OP_X_WIDTH(16), .OP_Y_WIDTH(16)) if1 ();
   serial_mul_if #(.OP_X_WIDTH(16), .OP_Y_WIDTH(16)) if4 ();

   serial_multiplier_ext #(.OP_X_WIDTH(16), .OP_Y_WIDTH(16), .BITS_PER_CYCLE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(if1.slave));
   serial_multiplier_ext #(.OP_X_WIDTH(16), .OP_Y_WIDTH(16), .BITS_PER_CYCLE(4)) u4 (
      .clk(clk), .rst_n(rst_n), .bus(if4.slave));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [31:0] q1[$];
   logic [31:0] q4[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitors: every valid_out pops the oldest expected product.
   always @(negedge clk) if (rst_n && if1.valid_out) begin
      if (q1.size() == 0) check("b1 spurious valid_out", 32'(if1.valid_out), 32'd0);
      else check("b1 out_mul", if1.out_mul, q1.pop_front());
   end
   always @(negedge clk) if (rst_n && if4.valid_out) begin
      if (q4.size() == 0) check("b4 spurious valid_out", 32'(if4.valid_out), 32'd0);
      else check("b4 out_mul", if4.out_mul, q4.pop_front());
   end

   function automatic logic rdy(input int b);
      return b == 1 ? if1.ready : if4.ready;
   endfunction
   function automatic logic vld(input int b);
      return b == 1 ? if1.valid_out : if4.valid_out;
   endfunction

   task automatic drive(input int b, input logic st, input logic s, input logic [15:0] x, input logic [15:0] y);
      if (b == 1) begin
         if1.start = st; if1.signed_mode = s; if1.in_x = x; if1.in_y = y;
      end else begin
         if4.start = st; if4.signed_mode = s; if4.in_x = x; if4.in_y = y;
      end
   endtask

   task automatic push(input int b, input logic [31:0] e);
      if (b == 1) q1.push_back(e);
      else q4.push_back(e);
   endtask

   task automatic run_op(input int b, input logic s, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] exp, input bit poke);
      int steps = (b == 1) ? 16 : 4;
      int n = 0;
      int lo = 0;
      @(negedge clk);
      drive(b, 1'b1, s, x, y);
      push(b, exp);
      @(posedge clk); #1;
      drive(b, 1'b0, !s, x ^ 16'h5a5a, y ^ 16'ha5a5);
      lo = rdy(b) ? 0 : 1;
      while (!vld(b) && n < 200) begin
         if (poke && n == 2) drive(b, 1'b1, !s, 16'd2, 16'd3);
         if (poke && n == 3) drive(b, 1'b0, s, 16'd0, 16'd0);
         @(posedge clk); #1;
         n++;
         if (!rdy(b)) lo++;
      end
      check($sformatf("b%0d latency edges after accept", b), n, steps);
      check($sformatf("b%0d ready low cycles", b), lo, steps + 1);
      @(posedge clk); #1;
      check($sformatf("b%0d ready after done", b), 32'(rdy(b)), 32'd1);
   endtask

   task automatic b2b(input int b);
      int steps = (b == 1) ? 16 : 4;
      int acc[3];
      int n;
      logic [15:0] x;
      logic [15:0] y;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         x = 16'($urandom_range(0, 1000));
         y = 16'($urandom_range(0, 1000));
         drive(b, 1'b1, 1'b0, x, y);
         push(b, 32'(x) * 32'(y));
         n = 0;
         while (!rdy(b) && n < 200) begin
            @(negedge clk);
            n++;
         end
         @(posedge clk); #1;
         acc[k] = cyc;
      end
      drive(b, 1'b0, 1'b0, 16'd0, 16'd0);
      check($sformatf("b%0d b2b spacing 0-1", b), acc[1] - acc[0], steps + 2);
      check($sformatf("b%0d b2b spacing 1-2", b), acc[2] - acc[1], steps + 2);
      repeat (steps + 6) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
      drive(4, 1'b0, 1'b0, 16'd0, 16'd0);
      repeat (3) @(posedge clk);
      #1;
      check("b1 reset ready", 32'(if1.ready), 32'd1);
      check("b1 reset valid", 32'(if1.valid_out), 32'd0);
      check("b1 reset out_mul", if1.out_mul, 32'd0);
      check("b4 reset out_mul", if4.out_mul, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      run_op(1, 1'b0, 16'd7, 16'd9, 32'd63, 1'b0);
      run_op(4, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
      for (int b = 1; b <= 4; b += 3) begin
         run_op(b, 1'b1, 16'hFFFD, 16'd5, 32'hFFFF_FFF1, 1'b0);
         run_op(b, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
         run_op(b, 1'b1, 16'h7FFF, 16'hFFFF, 32'hFFFF_8001, 1'b0);
      end

      run_op(1, 1'b0, 16'd11, 16'd13, 32'd143, 1'b1);
      repeat (40) @(negedge clk);
      run_op(4, 1'b0, 16'd20, 16'd30, 32'd600, 1'b1);
      repeat (20) @(negedge clk);

      b2b(1);
      b2b(4);

      @(negedge clk);
      drive(1, 1'b1, 1'b0, 16'd100, 16'd200);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
      repeat (5) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      check("b1 ready after mid-run reset", 32'(if1.ready), 32'd1);
      check("b1 valid after mid-run reset", 32'(if1.valid_out), 32'd0);
      check("b1 out_mul after mid-run reset", if1.out_mul, 32'd0);
      check("b4 out_mul after reset", if4.out_mul, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (25) @(negedge clk);
      run_op(1, 1'b0, 16'd5, 16'd6, 32'd30, 1'b0);
      run_op(4, 1'b0, 16'd5, 16'd6, 32'd30, 1'b0);

      repeat (5) @(negedge clk);
      check("b1 scoreboard drained", q1.size(), 32'd0);
      check("b4 scoreboard drained", q4.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
